// File: rtl/tt_um_timer_ctrl_if.sv
// Host-side bundle of the interval timer: config handshake, run commands, event handshake, status.
// The cfg_prescale_i member exists only when TIMER_PRESCALE_EN is defined.
interface tt_um_timer_ctrl_if #(
   parameter int BW = 8
`ifdef TIMER_PRESCALE_EN
   , parameter int PS_BW = 4
`endif
);
   logic          cfg_valid_i;
   logic          cfg_ready_o;
   logic [BW-1:0] cfg_period_i;
   logic          cfg_mode_i;
`ifdef TIMER_PRESCALE_EN
   logic [PS_BW-1:0] cfg_prescale_i;
`endif
   logic          start_i;
   logic          stop_i;
   logic          evt_valid_o;
   logic          evt_ready_i;
   logic          overrun_o;
   logic          busy_o;
   logic [BW-1:0] count_o;

   modport master (
      output cfg_valid_i, cfg_period_i, cfg_mode_i,
`ifdef TIMER_PRESCALE_EN
      output cfg_prescale_i,
`endif
      output start_i, stop_i, evt_ready_i,
      input  cfg_ready_o, evt_valid_o, overrun_o, busy_o, count_o
   );

   modport slave (
      input  cfg_valid_i, cfg_period_i, cfg_mode_i,
`ifdef TIMER_PRESCALE_EN
      input  cfg_prescale_i,
`endif
      input  start_i, stop_i, evt_ready_i,
      output cfg_ready_o, evt_valid_o, overrun_o, busy_o, count_o
   );
endinterface

// File: rtl/tt_um_timer_ctrl.sv
// Programmable interval timer controller: one-shot/periodic terminal-count events with overrun flag.
// Optional clock prescaler enabled by defining TIMER_PRESCALE_EN.
module tt_um_timer_ctrl #(
   parameter int BW = 8
`ifdef TIMER_PRESCALE_EN
   , parameter int PS_BW = 4
`endif
) (
   input logic               clk_i,
   input logic               rst_ni,
   tt_um_timer_ctrl_if.slave bus
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e        state_q;
   logic [BW-1:0] count_q;
   logic [BW-1:0] period_q;
   logic          mode_q;
   logic          evt_valid_q;
   logic          overrun_q;

   logic          evt_valid_d;
   logic          overrun_d;
   logic          cfg_fire_s;
   logic          tick_s;
   logic          terminal_s;
   logic          gen_evt_s;
   logic          run_end_s;

`ifdef TIMER_PRESCALE_EN
   logic [PS_BW-1:0] prescale_q;
   logic [PS_BW-1:0] ps_q;
   logic [PS_BW-1:0] ps_d;

   // Prescaler advances only while running; any exit from RUN or idle time keeps it at zero.
   always_comb begin
      ps_d = {PS_BW{1'b0}};
      if ((state_q == ST_RUN) && !run_end_s && !tick_s) begin
         ps_d = ps_q + {{(PS_BW-1){1'b0}}, 1'b1};
      end else begin
         ps_d = {PS_BW{1'b0}};
      end
   end
   assign tick_s = (ps_q == prescale_q);
`else
   assign tick_s = 1'b1;
`endif

   // Terminal detection, run exit and event/overrun next-state.
   always_comb begin
      cfg_fire_s  = (state_q == ST_IDLE) && bus.cfg_valid_i;
      terminal_s  = tick_s && (count_q == period_q);
      gen_evt_s   = (state_q == ST_RUN) && terminal_s;
      run_end_s   = (state_q == ST_RUN) && (bus.stop_i || (gen_evt_s && !mode_q));
      evt_valid_d = evt_valid_q;
      overrun_d   = overrun_q;
      if (gen_evt_s) begin
         evt_valid_d = 1'b1;
      end else if (evt_valid_q && bus.evt_ready_i) begin
         evt_valid_d = 1'b0;
      end else begin
         evt_valid_d = evt_valid_q;
      end
      if (cfg_fire_s) begin
         overrun_d = 1'b0;
      end else if (gen_evt_s && evt_valid_q && !bus.evt_ready_i) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_q;
      end
   end

   // Controller FSM with counter, latched configuration and event flags.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         count_q     <= {BW{1'b0}};
         period_q    <= {BW{1'b0}};
         mode_q      <= 1'b0;
         evt_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef TIMER_PRESCALE_EN
         prescale_q  <= {PS_BW{1'b0}};
         ps_q        <= {PS_BW{1'b0}};
`endif
      end else begin
         evt_valid_q <= evt_valid_d;
         overrun_q   <= overrun_d;
`ifdef TIMER_PRESCALE_EN
         ps_q        <= ps_d;
`endif
         case (state_q)
            ST_IDLE: begin
               count_q <= {BW{1'b0}};
               if (cfg_fire_s) begin
                  period_q <= bus.cfg_period_i;
                  mode_q   <= bus.cfg_mode_i;
`ifdef TIMER_PRESCALE_EN
                  prescale_q <= bus.cfg_prescale_i;
`endif
               end
               if (bus.start_i) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (run_end_s) begin
                  state_q <= ST_IDLE;
                  count_q <= {BW{1'b0}};
               end else if (tick_s) begin
                  // Full-range period wraps naturally; terminal match resets before any carry.
                  count_q <= terminal_s ? {BW{1'b0}} : count_q + {{(BW-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state_q <= ST_IDLE;
               count_q <= {BW{1'b0}};
            end
         endcase
      end
   end

   assign bus.cfg_ready_o = (state_q == ST_IDLE);
   assign bus.busy_o      = (state_q == ST_RUN);
   assign bus.evt_valid_o = evt_valid_q;
   assign bus.overrun_o   = overrun_q;
   assign bus.count_o     = count_q;

endmodule

// File: doc/tt_um_timer_ctrl.md
Name: tt_um_timer_ctrl

Overview:
Controller that sequences a BW-bit up-counter datapath as a programmable interval timer.
- Accepts a period/mode configuration over a valid/ready handshake.
- Runs the counter on start/stop commands.
- Emits terminal-count events on a valid/ready output, with sticky overrun detection.
- Sits between a host/config FSM and any logic that needs periodic or one-shot ticks.

Parameters:
BW, 8, counter and period width in bits
PS_BW, 4, prescaler width in bits (used only when TIMER_PRESCALE_EN is defined)

Ports:
clk_i  input  1  single clock
rst_ni  input  1  asynchronous active-low reset
cfg_valid_i  input  1  configuration offered
cfg_ready_o  output  1  configuration accepted (high only in IDLE)
cfg_period_i  input  BW  terminal count P; event interval is P+1 ticks
cfg_mode_i  input  1  0 = one-shot, 1 = periodic
start_i  input  1  start request (honoured only in IDLE)
stop_i  input  1  stop request (honoured only in RUN)
evt_valid_o  output  1  terminal-count event pending
evt_ready_i  input  1  event consumer ready
overrun_o  output  1  sticky: an event was lost while one was pending
busy_o  output  1  state == RUN
count_o  output  BW  current counter value

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous and active-low.
- Reset (rst_ni=0, asynchronous, including mid-operation):
  - state=IDLE, count_o=0, period_q=0, mode_q=0.
  - evt_valid_o=0, overrun_o=0, busy_o=0.
  - cfg_ready_o=1, since it is combinationally (state==IDLE).
- FSM has two states, IDLE and RUN.
- IDLE:
  - count held at 0.
  - cfg_valid_i & cfg_ready_o latches period_q, mode_q and clears overrun_o.
  - start_i moves to RUN at the next edge, count=0.
  - If cfg handshake and start_i coincide, the new config applies to that run.
  - stop_i is ignored.
- RUN:
  - Per tick edge: if count==period_q, generate event and set count=0; else count+=1.
  - tick is always 1 unless TIMER_PRESCALE_EN is defined.
  - Result: evt_valid_o first rises at the (P+1)th rising edge after the edge that samples start_i.
  - Terminal in one-shot mode: also go to IDLE.
  - Terminal in periodic mode: stay in RUN; count wraps to 0.
  - P=0 gives an event on every tick. P=2^BW-1 is a full-range wrap; no carry out.
  - stop_i goes to IDLE at the next edge with count=0; any pending event is retained.
  - stop_i coinciding with terminal: the event is still generated, then IDLE.
  - start_i is ignored in RUN.
  - cfg_ready_o=0 in RUN; config cannot change mid-run.
- Event handshake:
  - evt_valid_o is set on a generated event and held until the cycle with evt_valid_o & evt_ready_i.
  - New event in the same cycle as a completing handshake: evt_valid_o stays 1, no overrun.
  - New event while evt_valid_o=1 & evt_ready_i=0: event dropped, overrun_o set to 1. overrun_o stays 1 until the next cfg handshake or reset.
- All outputs are registered except cfg_ready_o and busy_o, which are decoded from the state register.

Optional Feature:
TIMER_PRESCALE_EN
- Defined:
  - Adds port cfg_prescale_i (input, PS_BW), latched with the config handshake.
  - A PS_BW-bit prescaler pulses tick once every S+1 clocks, where S is the latched prescale value.
  - Prescaler clears to 0 on start, stop and reset.
  - The first tick occurs S+1 clocks after the start edge.
  - Event interval becomes (P+1)*(S+1) clocks.
- Undefined: port absent, tick=1 every cycle, no prescaler logic.

Test Plan:
1. Reset mid-run: P=5 periodic, start, assert rst_ni=0 asynchronously at count=3 -> count_o, evt_valid_o, overrun_o, busy_o all 0 immediately; cfg_ready_o=1.
2. Periodic with ready tied 1: P=3, mode=1, start -> evt_valid_o pulses 1 cycle at edges 4, 8, 12 after the start edge; count_o sequence 0,1,2,3,0; overrun_o=0.
3. One-shot: P=2, mode=0, start -> single event at edge 3; busy_o drops the same edge; count_o=0; no further events over 20 cycles.
4. Overrun: P=1 periodic, evt_ready_i=0 -> evt_valid_o at edge 2, overrun_o=1 at edge 4. Raise evt_ready_i -> one handshake, overrun_o stays 1. Cfg handshake in IDLE -> overrun_o=0.
5. Boundary commands: stop_i at count=P=4 -> event generated and state IDLE. start_i with cfg_valid_i (P=7) in the same cycle -> first event at edge 8. start_i in RUN is ignored. P=0 gives an event every cycle.
6. TIMER_PRESCALE_EN with S=2, P=1 -> events every 6 clocks, first at clock 6 after start; stop then start restarts the prescaler from 0.
